pipe_hazard_ctrl: RTL and testbench

Central stall/flush scheduler for the 5-stage RV32 pipeline. Drives the 2-bit sel control of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable. Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory/peripheral (keypad) waits. Also provides a wait timeout and saturating performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 5 +
 rtl/hazard_detect.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 64 ++++++
 tb/tb_pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: pipeline register select codes and hazard controller states
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {SEL_NORMAL = 2'b00, SEL_HOLD = 2'b01, SEL_CLEAR = 2'b11} sel_e;
  typedef enum logic {RUN, MEM_WAIT} state_e;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use and taken-branch detection from ID/EX
module hazard_detect (
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_used_i,
  input  logic       id_rs2_used_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_rd_wren_i,
  input  logic       ex_is_load_i,
  input  logic       ex_br_taken_i,
  output logic       load_use,
  output logic       branch_flush
);
  assign load_use = ex_is_load_i && ex_rd_wren_i && ex_rd_addr_i != 5'd0 &&
                    ((id_rs1_used_i && id_rs1_addr_i == ex_rd_addr_i) ||
                     (id_rs2_used_i && id_rs2_addr_i == ex_rd_addr_i));
  assign branch_flush = ex_br_taken_i;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler with memory-wait timeout and perf counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_used_i,
  input  logic        id_rs2_used_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_rd_wren_i,
  input  logic        ex_is_load_i,
  input  logic        ex_br_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ready_i,
  output logic        pc_en_o,
  output logic [1:0]  if_id_sel_o,
  output logic [1:0]  id_ex_sel_o,
  output logic [1:0]  ex_mem_sel_o,
  output logic [1:0]  mem_wb_sel_o,
  output logic        mem_err_o,
  output logic [31:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);
  state_e state;
  logic [TO_W-1:0] cnt;
  logic load_use, branch_flush, at_limit, rel, stall_mem, flush, lu;
  hazard_detect u_hd (
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_wren_i(ex_rd_wren_i),
    .ex_is_load_i(ex_is_load_i), .ex_br_taken_i(ex_br_taken_i),
    .load_use(load_use), .branch_flush(branch_flush)
  );
  assign at_limit  = cnt == TO_W'(MEM_TIMEOUT);
  assign rel       = state == MEM_WAIT && (mem_ready_i || at_limit);
  assign stall_mem = state == RUN ? mem_req_i && !mem_ready_i : !rel;
  assign flush     = !stall_mem && branch_flush;
  assign lu        = !stall_mem && !branch_flush && load_use;
  // a release cycle behaves like RUN, so pending EX hazards apply there too
  assign pc_en_o      = !i_rst && !stall_mem && !lu;
  assign if_id_sel_o  = i_rst ? SEL_CLEAR : stall_mem ? SEL_HOLD : flush ? SEL_CLEAR : lu ? SEL_HOLD : SEL_NORMAL;
  assign id_ex_sel_o  = i_rst ? SEL_CLEAR : stall_mem ? SEL_HOLD : (flush || lu) ? SEL_CLEAR : SEL_NORMAL;
  assign ex_mem_sel_o = i_rst ? SEL_CLEAR : stall_mem ? SEL_HOLD : SEL_NORMAL;
  assign mem_wb_sel_o = (i_rst || stall_mem) ? SEL_CLEAR : SEL_NORMAL;
  assign mem_err_o    = !i_rst && state == MEM_WAIT && at_limit && !mem_ready_i;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= RUN;
      cnt         <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state <= stall_mem ? MEM_WAIT : RUN;
      cnt   <= !stall_mem ? '0 : state == RUN ? TO_W'(1) : cnt + TO_W'(1);
      if (!pc_en_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (flush && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized model comparison on two timeout settings
module tb_pipe_hazard_ctrl;
  logic i_clk = 0, i_rst = 0;
  logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
  logic u1 = 0, u2 = 0, wren = 0, ld = 0, taken = 0, req = 0, rdy = 0;
  logic pc_en [2];
  logic [1:0] s_ifid [2], s_idex [2], s_exmem [2], s_memwb [2];
  logic err [2];
  logic [31:0] sc [2];
  logic [15:0] fc [2];
  logic [9:0] obs [2];
  int errs = 0, checks = 0;
  localparam logic [9:0] NORM = 10'b1_00_00_00_00_0;
  localparam logic [9:0] STALL = 10'b0_01_01_01_11_0;
  localparam logic [9:0] LU = 10'b0_01_11_00_00_0;
  localparam logic [9:0] BR = 10'b1_11_11_00_00_0;
  localparam logic [9:0] RST = 10'b0_11_11_11_11_0;
  localparam logic [9:0] REL_ERR = 10'b1_00_00_00_00_1;
  always #5 i_clk = ~i_clk;
  for (genvar k = 0; k < 2; k++) begin : g_dut
    pipe_hazard_ctrl #(.MEM_TIMEOUT(k == 0 ? 255 : 3), .TO_W(8)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
      .ex_rd_addr_i(rd), .ex_rd_wren_i(wren), .ex_is_load_i(ld), .ex_br_taken_i(taken),
      .mem_req_i(req), .mem_ready_i(rdy),
      .pc_en_o(pc_en[k]), .if_id_sel_o(s_ifid[k]), .id_ex_sel_o(s_idex[k]),
      .ex_mem_sel_o(s_exmem[k]), .mem_wb_sel_o(s_memwb[k]), .mem_err_o(err[k]),
      .stall_cnt_o(sc[k]), .flush_cnt_o(fc[k])
    );
    assign obs[k] = {pc_en[k], s_ifid[k], s_idex[k], s_exmem[k], s_memwb[k], err[k]};
  end
  task automatic idle();
    {rs1, rs2, rd, u1, u2, wren, ld, taken, req, rdy} = '0;
  endtask
  task automatic edge_step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic do_reset();
    idle();
    i_rst = 1;
    edge_step();
    i_rst = 0;
  endtask
  task automatic set_load_use();
    ld = 1; wren = 1; rd = 5'd5; rs2 = 5'd5; u2 = 1; rs1 = 5'd7; u1 = 1;
  endtask
  task automatic test_reset();
    idle();
    i_rst = 1;
    @(negedge i_clk);
    checks++; if (obs[0] !== RST) begin errs++; $display("FAIL reset_outputs got=%b want=%b", obs[0], RST); end
    edge_step();
    i_rst = 0;
    @(negedge i_clk);
    checks++; if (obs[0] !== NORM) begin errs++; $display("FAIL post_reset_outputs got=%b want=%b", obs[0], NORM); end
    checks++; if (sc[0] !== 0 || fc[0] !== 0) begin errs++; $display("FAIL reset_counters got=%0d/%0d want=0/0", sc[0], fc[0]); end
    edge_step();
  endtask
  task automatic test_load_use();
    do_reset();
    set_load_use();
    @(negedge i_clk);
    checks++; if (obs[0] !== LU) begin errs++; $display("FAIL load_use got=%b want=%b", obs[0], LU); end
    edge_step();
    idle();
    @(negedge i_clk);
    checks++; if (obs[0] !== NORM) begin errs++; $display("FAIL load_use_after got=%b want=%b", obs[0], NORM); end
    checks++; if (sc[0] !== 32'd1) begin errs++; $display("FAIL load_use_stall_cnt got=%0d want=1", sc[0]); end
    edge_step();
  endtask
  task automatic test_rd0();
    do_reset();
    ld = 1; wren = 1; rd = 0; rs1 = 0; u1 = 1;
    @(negedge i_clk);
    checks++; if (obs[0] !== NORM) begin errs++; $display("FAIL rd0_no_stall got=%b want=%b", obs[0], NORM); end
    edge_step();
    checks++; if (sc[0] !== 32'd0) begin errs++; $display("FAIL rd0_stall_cnt got=%0d want=0", sc[0]); end
  endtask
  task automatic test_branch_lu();
    do_reset();
    set_load_use();
    taken = 1;
    @(negedge i_clk);
    checks++; if (obs[0] !== BR) begin errs++; $display("FAIL branch_lu got=%b want=%b", obs[0], BR); end
    edge_step();
    idle();
    checks++; if (fc[0] !== 16'd1 || sc[0] !== 32'd0) begin errs++; $display("FAIL branch_lu_cnt got=%0d/%0d want=1/0", fc[0], sc[0]); end
  endtask
  task automatic test_mem_wait();
    do_reset();
    req = 1; taken = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      checks++; if (obs[0] !== STALL) begin errs++; $display("FAIL mem_wait_cyc%0d got=%b want=%b", c, obs[0], STALL); end
      edge_step();
    end
    rdy = 1;
    @(negedge i_clk);
    checks++; if (obs[0] !== BR) begin errs++; $display("FAIL mem_release_branch got=%b want=%b", obs[0], BR); end
    edge_step();
    idle();
    checks++; if (sc[0] !== 32'd4 || fc[0] !== 16'd1) begin errs++; $display("FAIL mem_wait_cnt got=%0d/%0d want=4/1", sc[0], fc[0]); end
  endtask
  task automatic test_timeout();
    do_reset();
    req = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      checks++; if (obs[1] !== STALL) begin errs++; $display("FAIL timeout_wait_cyc%0d got=%b want=%b", c, obs[1], STALL); end
      edge_step();
    end
    @(negedge i_clk);
    checks++; if (obs[1] !== REL_ERR) begin errs++; $display("FAIL timeout_release got=%b want=%b", obs[1], REL_ERR); end
    edge_step();
    idle();
    @(negedge i_clk);
    checks++; if (obs[1] !== NORM) begin errs++; $display("FAIL timeout_back_to_run got=%b want=%b", obs[1], NORM); end
    checks++; if (sc[1] !== 32'd3) begin errs++; $display("FAIL timeout_stall_cnt got=%0d want=3", sc[1]); end
    edge_step();
  endtask
  task automatic test_reset_mid_wait();
    do_reset();
    req = 1;
    edge_step();
    i_rst = 1;
    @(negedge i_clk);
    checks++; if (obs[0] !== RST) begin errs++; $display("FAIL mid_wait_reset got=%b want=%b", obs[0], RST); end
    edge_step();
    i_rst = 0;
    idle();
    @(negedge i_clk);
    checks++; if (obs[0] !== NORM) begin errs++; $display("FAIL mid_wait_after got=%b want=%b", obs[0], NORM); end
    checks++; if (sc[0] !== 0 || fc[0] !== 0) begin errs++; $display("FAIL mid_wait_counters got=%0d/%0d want=0/0", sc[0], fc[0]); end
    edge_step();
  endtask
  task automatic test_random();
    bit waiting [2];
    int wn [2];
    longint ms [2], mf [2];
    int to [2] = '{255, 3};
    do_reset();
    for (int k = 0; k < 2; k++) begin waiting[k] = 0; wn[k] = 0; ms[k] = 0; mf[k] = 0; end
    for (int n = 0; n < 600; n++) begin
      i_rst = ($urandom_range(99) < 2);
      rs1 = 5'($urandom_range(3)); rs2 = 5'($urandom_range(3)); rd = 5'($urandom_range(3));
      u1 = 1'($urandom); u2 = 1'($urandom); wren = 1'($urandom); ld = 1'($urandom);
      taken = ($urandom_range(9) < 2); req = ($urandom_range(9) < 3); rdy = ($urandom_range(9) < 4);
      @(negedge i_clk);
      for (int k = 0; k < 2; k++) begin
        bit stalled, ex_err, br, hz;
        logic [9:0] exp_v;
        stalled = waiting[k] ? !(rdy || wn[k] >= to[k]) : (req && !rdy);
        ex_err = waiting[k] && !rdy && wn[k] >= to[k];
        br = !stalled && taken;
        hz = !stalled && !taken && ld && wren && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        exp_v = i_rst ? RST : stalled ? STALL : br ? (BR | 10'(ex_err)) : hz ? (LU | 10'(ex_err)) : (NORM | 10'(ex_err));
        checks++; if (obs[k] !== exp_v) begin errs++; $display("FAIL rand_outputs dut%0d cyc%0d got=%b want=%b", k, n, obs[k], exp_v); end
        checks++; if (sc[k] !== 32'(ms[k]) || fc[k] !== 16'(mf[k])) begin errs++; $display("FAIL rand_counters dut%0d cyc%0d got=%0d/%0d want=%0d/%0d", k, n, sc[k], fc[k], ms[k], mf[k]); end
        if (i_rst) begin
          waiting[k] = 0; wn[k] = 0; ms[k] = 0; mf[k] = 0;
        end else begin
          waiting[k] = stalled;
          wn[k] = stalled ? wn[k] + 1 : 0;
          if (!exp_v[9] && ms[k] < 64'hFFFF_FFFF) ms[k]++;
          if (br && mf[k] < 64'hFFFF) mf[k]++;
        end
      end
      edge_step();
    end
    i_rst = 0;
    idle();
  endtask
  initial begin
    #1;
    test_reset();
    test_load_use();
    test_rd0();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
